// File: rtl/instruction_decode_if.sv
// IF/ID inputs, write-back port and ID/EX outputs of the decode stage.
// The slave modport is the decoder; master is the surrounding pipeline.
interface instruction_decode_if;
  logic [31:0] pc_out1_s1;
  logic [31:0] instruction_s1;
  logic        flush;
  logic        reg_write_s5;
  logic [4:0]  write_reg_s5;
  logic [31:0] write_data_s5;
  logic        stall;
  logic [31:0] pc_out1_s2;
  logic [31:0] read_data1_s2;
  logic [31:0] read_data2_s2;
  logic [31:0] imm_s2;
  logic [4:0]  rs_s2;
  logic [4:0]  rt_s2;
  logic [4:0]  write_reg_s2;
  logic [3:0]  alu_op_s2;
  logic        reg_write_s2;
  logic        mem_read_s2;
  logic        mem_write_s2;
  logic        mem_to_reg_s2;
  logic        alu_src_s2;
  logic        branch_s2;

  modport master (
    output pc_out1_s1, instruction_s1, flush, reg_write_s5, write_reg_s5, write_data_s5,
    input  stall, pc_out1_s2, read_data1_s2, read_data2_s2, imm_s2, rs_s2, rt_s2,
           write_reg_s2, alu_op_s2, reg_write_s2, mem_read_s2, mem_write_s2, mem_to_reg_s2,
           alu_src_s2, branch_s2
  );

  modport slave (
    input  pc_out1_s1, instruction_s1, flush, reg_write_s5, write_reg_s5, write_data_s5,
    output stall, pc_out1_s2, read_data1_s2, read_data2_s2, imm_s2, rs_s2, rt_s2,
           write_reg_s2, alu_op_s2, reg_write_s2, mem_read_s2, mem_write_s2, mem_to_reg_s2,
           alu_src_s2, branch_s2
  );
endinterface

// File: rtl/instruction_decode.sv
// Decode stage: control decode, register file with write-through reads,
// load-use hazard detection and the ID/EX pipeline register.
module instruction_decode #(
  parameter int unsigned NUM_REGS = 32
) (
  input logic                 clk,
  input logic                 reset,
  instruction_decode_if.slave bus
);
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b100011;
  localparam logic [5:0] OpLw    = 6'b101011;
  localparam logic [5:0] OpSt    = 6'b000100;
  localparam logic [5:0] OpBeq   = 6'b000101;

  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnMult = 6'b011011;
  localparam logic [5:0] FnAnd  = 6'b001010;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluMult = 4'b1000;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm;

  assign opcode = bus.instruction_s1[31:26];
  assign rs     = bus.instruction_s1[25:21];
  assign rt     = bus.instruction_s1[20:16];
  assign rd     = bus.instruction_s1[15:11];
  assign funct  = bus.instruction_s1[5:0];
  assign imm    = {{16{bus.instruction_s1[15]}}, bus.instruction_s1[15:0]};

  // Register file; reset seeds reg[i] = i so test programs have nonzero operands.
  logic [31:0] regs [NUM_REGS];
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 32'(i);
      end
    end else if (bus.reg_write_s5 && (bus.write_reg_s5 != 5'd0)) begin
      regs[bus.write_reg_s5] <= bus.write_data_s5;
    end
  end

  always_comb begin
    read_data1 = regs[rs];
    read_data2 = regs[rt];
    if (rs == 5'd0) begin
      read_data1 = '0;
    end else if (bus.reg_write_s5 && (bus.write_reg_s5 == rs)) begin
      read_data1 = bus.write_data_s5;
    end
    if (rt == 5'd0) begin
      read_data2 = '0;
    end else if (bus.reg_write_s5 && (bus.write_reg_s5 == rt)) begin
      read_data2 = bus.write_data_s5;
    end
  end

  // Control decode
  logic       reg_write;
  logic       reg_dst;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       alu_src;
  logic       branch;
  logic [3:0] alu_op;
  logic [4:0] write_reg;

  always_comb begin
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    alu_op     = AluAnd;
    case (opcode)
      OpRtype: begin
        // Unknown funct keeps reg_dst but never writes, which also makes 0x0 a NOP.
        reg_dst = 1'b1;
        case (funct)
          FnAdd:   begin reg_write = 1'b1; alu_op = AluAdd;  end
          FnSub:   begin reg_write = 1'b1; alu_op = AluSub;  end
          FnMult:  begin reg_write = 1'b1; alu_op = AluMult; end
          FnAnd:   begin reg_write = 1'b1; alu_op = AluAnd;  end
          default: reg_write = 1'b0;
        endcase
      end
      OpAddi: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = AluAdd;
      end
      OpLw: begin
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 1'b1;
        alu_op     = AluAdd;
      end
      OpSt: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = AluAdd;
      end
      OpBeq: begin
        branch = 1'b1;
        alu_op = AluSub;
      end
      default: ;
    endcase
    write_reg = reg_dst ? rd : rt;
  end

  // Load-use: the load in ID/EX targets a register this instruction reads.
  assign bus.stall = !reset && !bus.flush && bus.mem_read_s2 && (bus.write_reg_s2 != 5'd0) &&
                     ((bus.write_reg_s2 == rs) || (bus.write_reg_s2 == rt));

  // ID/EX register; flush and stall both insert a fully zeroed bubble.
  always_ff @(posedge clk) begin
    if (reset || bus.flush || bus.stall) begin
      bus.pc_out1_s2    <= '0;
      bus.read_data1_s2 <= '0;
      bus.read_data2_s2 <= '0;
      bus.imm_s2        <= '0;
      bus.rs_s2         <= '0;
      bus.rt_s2         <= '0;
      bus.write_reg_s2  <= '0;
      bus.alu_op_s2     <= '0;
      bus.reg_write_s2  <= 1'b0;
      bus.mem_read_s2   <= 1'b0;
      bus.mem_write_s2  <= 1'b0;
      bus.mem_to_reg_s2 <= 1'b0;
      bus.alu_src_s2    <= 1'b0;
      bus.branch_s2     <= 1'b0;
    end else begin
      bus.pc_out1_s2    <= bus.pc_out1_s1;
      bus.read_data1_s2 <= read_data1;
      bus.read_data2_s2 <= read_data2;
      bus.imm_s2        <= imm;
      bus.rs_s2         <= rs;
      bus.rt_s2         <= rt;
      bus.write_reg_s2  <= write_reg;
      bus.alu_op_s2     <= alu_op;
      bus.reg_write_s2  <= reg_write;
      bus.mem_read_s2   <= mem_read;
      bus.mem_write_s2  <= mem_write;
      bus.mem_to_reg_s2 <= mem_to_reg;
      bus.alu_src_s2    <= alu_src;
      bus.branch_s2     <= branch;
    end
  end
endmodule

// File: tb/tb_instruction_decode.sv
// Directed table-driven bench for the decode stage, plus a mid-run reset sequence.
module tb_instruction_decode;
  localparam logic [5:0] OpAddi = 6'b100011;
  localparam logic [5:0] OpLw   = 6'b101011;
  localparam logic [5:0] OpSt   = 6'b000100;
  localparam logic [5:0] OpBeq  = 6'b000101;

  // {pc, rd1, rd2, imm, rs, rt, wr, alu_op, {rw, mr, mw, m2r, src, br}}
  typedef logic [152:0] s2_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        exp_stall;
    s2_t         exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [20];

  instruction_decode_if bus ();

  instruction_decode #(.NUM_REGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic s2_t ex(input logic [31:0] pc, input logic [31:0] rd1,
                             input logic [31:0] rd2, input logic [31:0] im,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                             input logic [3:0] alu, input logic [5:0] ctrl);
    return {pc, rd1, rd2, im, rs, rt, wr, alu, ctrl};
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] pc,
                               input logic flush, input logic wb_en, input logic [4:0] wb_reg,
                               input logic [31:0] wb_data, input logic stl, input s2_t e);
    vec_t v;
    v.instr = instr; v.pc = pc; v.flush = flush; v.wb_en = wb_en;
    v.wb_reg = wb_reg; v.wb_data = wb_data; v.exp_stall = stl; v.exp = e;
    return v;
  endfunction

  function automatic s2_t got_s2();
    return {bus.pc_out1_s2, bus.read_data1_s2, bus.read_data2_s2, bus.imm_s2, bus.rs_s2,
            bus.rt_s2, bus.write_reg_s2, bus.alu_op_s2, bus.reg_write_s2, bus.mem_read_s2,
            bus.mem_write_s2, bus.mem_to_reg_s2, bus.alu_src_s2, bus.branch_s2};
  endfunction

  task automatic check_s2(input string name, input s2_t exp);
    s2_t got;
    got = got_s2();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s s2 got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic check_stall(input string name, input logic exp);
    checks++;
    if (bus.stall !== exp) begin
      errors++;
      $display("FAIL %s stall got=%b want=%b", name, bus.stall, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                       input logic wb_en, input logic [4:0] wb_reg, input logic [31:0] wb_data);
    bus.instruction_s1 = instr;
    bus.pc_out1_s1     = pc;
    bus.flush          = flush;
    bus.reg_write_s5   = wb_en;
    bus.write_reg_s5   = wb_reg;
    bus.write_data_s5  = wb_data;
  endtask

  initial begin
    vecs[0]  = mkv(32'h0062_2020, 4, 0, 0, 0, 0, 0,
                   ex(4, 3, 2, 32'h2020, 3, 2, 4, 4'b0010, 6'b100000));
    vecs[1]  = mkv(r_ins(3, 1, 5, 6'b100010), 8, 0, 1, 3, 32'hDEAD, 0,
                   ex(8, 32'hDEAD, 1, 32'h2822, 3, 1, 5, 4'b0110, 6'b100000));
    vecs[2]  = mkv(r_ins(0, 3, 6, 6'b001010), 12, 0, 1, 0, 32'hBEEF, 0,
                   ex(12, 0, 32'hDEAD, 32'h300A, 0, 3, 6, 4'b0000, 6'b100000));
    vecs[3]  = mkv(i_ins(OpAddi, 0, 7, 16'hFFFF), 16, 0, 0, 0, 0, 0,
                   ex(16, 0, 7, 32'hFFFF_FFFF, 0, 7, 7, 4'b0010, 6'b100010));
    vecs[4]  = mkv(i_ins(OpLw, 2, 4, 16'h0008), 20, 0, 0, 0, 0, 0,
                   ex(20, 2, 4, 8, 2, 4, 4, 4'b0010, 6'b110110));
    vecs[5]  = mkv(r_ins(4, 1, 4, 6'b100010), 24, 0, 0, 0, 0, 1, '0);
    vecs[6]  = mkv(r_ins(4, 1, 4, 6'b100010), 24, 0, 0, 0, 0, 0,
                   ex(24, 4, 1, 32'h2022, 4, 1, 4, 4'b0110, 6'b100000));
    vecs[7]  = mkv(i_ins(OpLw, 1, 9, 16'h0000), 28, 0, 0, 0, 0, 0,
                   ex(28, 1, 9, 0, 1, 9, 9, 4'b0010, 6'b110110));
    vecs[8]  = mkv(i_ins(OpAddi, 9, 10, 16'h0005), 32, 1, 0, 0, 0, 0, '0);
    vecs[9]  = mkv(i_ins(OpBeq, 1, 2, 16'h8000), 36, 0, 0, 0, 0, 0,
                   ex(36, 1, 2, 32'hFFFF_8000, 1, 2, 2, 4'b0110, 6'b000001));
    vecs[10] = mkv(i_ins(OpSt, 5, 3, 16'h0004), 40, 0, 0, 0, 0, 0,
                   ex(40, 5, 32'hDEAD, 4, 5, 3, 3, 4'b0010, 6'b001010));
    vecs[11] = mkv(32'hFC00_0000, 44, 0, 0, 0, 0, 0,
                   ex(44, 0, 0, 0, 0, 0, 0, 4'b0000, 6'b000000));
    vecs[12] = mkv(r_ins(1, 2, 8, 6'b011011), 48, 0, 0, 0, 0, 0,
                   ex(48, 1, 2, 32'h401B, 1, 2, 8, 4'b1000, 6'b100000));
    vecs[13] = mkv(r_ins(1, 2, 8, 6'b111111), 52, 0, 0, 0, 0, 0,
                   ex(52, 1, 2, 32'h403F, 1, 2, 8, 4'b0000, 6'b000000));
    vecs[14] = mkv(32'h0000_0000, 56, 0, 0, 0, 0, 0,
                   ex(56, 0, 0, 0, 0, 0, 0, 4'b0000, 6'b000000));
    vecs[15] = mkv(i_ins(OpLw, 0, 5, 16'h0000), 60, 0, 0, 0, 0, 0,
                   ex(60, 0, 5, 0, 0, 5, 5, 4'b0010, 6'b110110));
    vecs[16] = mkv(r_ins(2, 5, 11, 6'b100000), 64, 0, 0, 0, 0, 1, '0);
    vecs[17] = mkv(r_ins(2, 5, 11, 6'b100000), 64, 0, 0, 0, 0, 0,
                   ex(64, 2, 5, 32'h5820, 2, 5, 11, 4'b0010, 6'b100000));
    vecs[18] = mkv(i_ins(OpLw, 1, 0, 16'h0000), 68, 0, 0, 0, 0, 0,
                   ex(68, 1, 0, 0, 1, 0, 0, 4'b0010, 6'b110110));
    vecs[19] = mkv(r_ins(0, 0, 12, 6'b100000), 72, 0, 0, 0, 0, 0,
                   ex(72, 0, 0, 32'h6020, 0, 0, 12, 4'b0010, 6'b100000));

    reset = 1'b1;
    drive(r_ins(4, 4, 4, 6'b100000), 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_s2("reset", '0);
    check_stall("reset", 1'b0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].instr, vecs[i].pc, vecs[i].flush, vecs[i].wb_en, vecs[i].wb_reg,
            vecs[i].wb_data);
      #1;
      check_stall($sformatf("vec%0d", i), vecs[i].exp_stall);
      @(posedge clk);
      #1;
      check_s2($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Write r5, then reset mid-run: pipeline clears and r5 reads 5 again.
    @(negedge clk);
    drive(i_ins(OpLw, 5, 6, 16'h0000), 80, 0, 1, 5, 32'h1234);
    @(posedge clk);
    #1;
    check_s2("pre_reset_lw", ex(80, 32'h1234, 6, 0, 5, 6, 6, 4'b0010, 6'b110110));
    @(negedge clk);
    reset = 1'b1;
    drive(r_ins(6, 5, 7, 6'b100000), 84, 0, 0, 0, 0);
    #1;
    check_stall("stall_in_reset", 1'b0);
    @(posedge clk);
    #1;
    check_s2("mid_reset", '0);
    @(negedge clk);
    reset = 1'b0;
    drive(r_ins(5, 5, 7, 6'b100000), 84, 0, 0, 0, 0);
    #1;
    check_stall("after_reset", 1'b0);
    @(posedge clk);
    #1;
    check_s2("after_reset", ex(84, 5, 5, 32'h3820, 5, 5, 7, 4'b0010, 6'b100000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_decode.md
# instruction_decode

Second pipeline stage of the RISC CPU: sits directly downstream of the fetch stage and consumes its IF/ID outputs (`pc_out1_s1`, `instruction_s1`). Decodes the instruction, reads the 32x32 register file (written back from stage 5), sign-extends the immediate, detects load-use hazards, and registers everything into the ID/EX pipeline register (`_s2` outputs) for the execute stage.

## Interface
- `NUM_REGS`, 32, register file depth; address width fixed at 5 bits.
- `clk`  in  1  rising-edge clock for the whole block.
- `reset`  in  1  synchronous, active-high.
- `pc_out1_s1`  in  32  PC+4 from fetch.
- `instruction_s1`  in  32  fetched instruction.
- `flush`  in  1  branch taken (fetch `pcSrc`); squashes the instruction currently in decode.
- `reg_write_s5`  in  1  write-back enable.
- `write_reg_s5`  in  5  write-back register address.
- `write_data_s5`  in  32  write-back data.
- `stall`  out  1  combinational; when high, fetch holds PC and IF/ID.
- `pc_out1_s2`  out  32  registered PC+4.
- `read_data1_s2`, `read_data2_s2`  out  32 each  rs/rt operand values.
- `imm_s2`  out  32  sign-extended `instruction[15:0]`.
- `rs_s2`, `rt_s2`  out  5 each  source addresses, for forwarding.
- `write_reg_s2`  out  5  destination: rd if `reg_dst`, else rt.
- `alu_op_s2`  out  4  ALU operation code.
- `reg_write_s2`, `mem_read_s2`, `mem_write_s2`, `mem_to_reg_s2`, `alu_src_s2`, `branch_s2`  out  1 each  control bits.

## Operation
- **Field split.** opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
- **Opcode decode.**
  - 000000 R-type: reg_write=1, reg_dst=1.
  - 100011 addi: reg_write=1, alu_src=1, alu_op=0010.
  - 101011 lw: reg_write=1, mem_read=1, mem_to_reg=1, alu_src=1, alu_op=0010.
  - 000100 st: mem_write=1, alu_src=1, alu_op=0010.
  - 000101 beq: branch=1, alu_op=0110.
  - Any other opcode, and the all-zero word: NOP, all controls 0 and alu_op=0000.
- **R-type funct decode.** 100000 add→0010; 100010 sub→0110; 011011 mult→1000; 001010 and→0000. Any other funct: R-type controls with reg_write forced to 0.
- **Register file.**
  - On reset, reg[i] <= i for all i (gives the test program nonzero operands).
  - Write happens on the clock edge when `reg_write_s5` is high and `write_reg_s5` != 0.
  - r0 always reads 0.
  - Reads are combinational with write-through: if the same-cycle write address equals the read address (and is nonzero), the read returns `write_data_s5`.
- **Load-use hazard.** `stall` = `mem_read_s2` AND `write_reg_s2` != 0 AND (`write_reg_s2` == rs OR `write_reg_s2` == rt of `instruction_s1`) AND NOT `flush`.
- **ID/EX update, every clock edge, in priority order.**
  - reset: all `_s2` outputs become 0.
  - else flush: bubble (all control bits 0; data fields are don't-care but are driven to 0).
  - else stall: bubble. The instruction stays in IF/ID because fetch holds, so it is decoded again next cycle.
  - else: load the decoded values.

## Timing
- Latency: one cycle from IF/ID to ID/EX.
- Register write to read visibility: 0 cycles, via write-through.
- `stall` is combinational from `instruction_s1` and the `_s2` registers. It lasts exactly one cycle per load-use pair, because the inserted bubble clears `mem_read_s2`.
- `stall` is 0 while reset is high and during the first cycle after reset.
- flush and stall in the same cycle: flush wins and `stall` is 0.
- Reset mid-operation: the pipeline register clears on that edge and the register file reinitialises to reg[i] = i.

## Test plan
- **Reset.** Hold reset for 2 cycles. Expect all `_s2` outputs 0, `stall`=0, and reading r5 returns 5.
- **R-type decode.** Apply `instruction_s1`=add r4,r3,r2 (0x00622020) and pc_out1_s1=4. Next cycle expect read_data1_s2=3, read_data2_s2=2, write_reg_s2=4, alu_op_s2=0010, reg_write_s2=1, pc_out1_s2=4.
- **Write-through.** reg_write_s5=1, write_reg_s5=3, write_data_s5=0xDEAD, while decoding an instruction with rs=3. Expect read_data1_s2=0xDEAD. A write to r0 leaves r0 reading 0.
- **Load-use.**
  - Decode lw with rt=4.
  - Next cycle present sub r4,r4,r1. Expect `stall`=1 and a bubble in s2 (reg_write_s2=0).
  - The cycle after, `stall`=0 and the sub issues with alu_op_s2=0110.
- **Flush.** Apply flush=1 while a valid addi is in IF/ID. Expect all s2 controls 0 next cycle. Flush concurrent with a load-use condition gives `stall`=0.
- **Unknown opcode.** Apply 0xFC000000. Expect a NOP in s2 with all controls 0.
